// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// One buffer entry pairs an instruction word with the address it was fetched from.
package fetch_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_DEPTH    = 2;
  localparam int          INSTR_BYTES  = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of fetch entries; head is a registered read, no bypass.
// Flush empties the FIFO and overrides a same-cycle push; pushes into a full FIFO are refused.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  fetch_entry_t                 i_push_dat,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order imem requests, DEPTH-entry response buffer, taken-branch redirect.
// Response in cycle k is presented in k+1; requests are credit-limited so the buffer never overflows.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int           N        = XLEN,
  parameter logic [N-1:0] RESET_PC = DEF_RESET_PC,
  parameter int           DEPTH    = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         PC_sel,
  input  logic [N-1:0] branch_target,
  input  logic         stall,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         valid_out,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] PC_out,
  output logic [N-1:0] NPC_out
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  r_fetch_pc;
  logic [N-1:0]  r_resp_pc;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_buf_count;
  logic [CW:0]   w_pending;
  logic [CW:0]   w_redir_drop;
  logic          w_buf_empty;
  logic          w_buf_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_accept;
  logic          w_keep;
  logic          w_push;
  logic [N-1:0]  w_pc_out;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_dat;

  assign w_valid = !rst && !PC_sel && !w_buf_empty;
  assign w_pop   = w_valid && !stall;

  // A head entry leaving this cycle frees its slot immediately, which is what sustains 1 instr/cycle.
  assign w_pending = {1'b0, r_out_cnt} + {1'b0, w_buf_count} - (CW+1)'(w_pop);
  assign imem_req  = !rst && !PC_sel && (w_pending < (CW+1)'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;

  assign w_keep     = imem_rvalid && (r_drop_cnt == '0) && !PC_sel;
  assign w_push     = w_keep && (!w_buf_full || w_pop);
  assign w_push_dat = '{pc: r_resp_pc, instr: imem_rdata};

  // Everything still owed by memory becomes stale; a response landing in the redirect cycle is already paid.
  assign w_redir_drop = {1'b0, r_drop_cnt} + {1'b0, r_out_cnt} - (CW+1)'(imem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (PC_sel) begin
      r_fetch_pc <= branch_target;
      r_resp_pc  <= branch_target;
      r_out_cnt  <= '0;
      r_drop_cnt <= w_redir_drop[CW-1:0];
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + N'(INSTR_BYTES);
      if (w_keep)   r_resp_pc  <= r_resp_pc + N'(INSTR_BYTES);
      r_out_cnt <= r_out_cnt + CW'(w_accept) - CW'(w_keep);
      if (imem_rvalid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (PC_sel),
    .o_head     (w_head),
    .o_count    (w_buf_count),
    .o_full     (w_buf_full),
    .o_empty    (w_buf_empty)
  );

  assign w_pc_out  = rst ? RESET_PC : w_head.pc;
  assign valid_out = w_valid;
  assign instr_out = rst ? '0 : w_head.instr;
  assign PC_out    = w_pc_out;
  assign NPC_out   = w_pc_out + N'(INSTR_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queued imem model with 1- or 2-cycle latency drives the main
// instance; a second instance with RESET_PC=FFFF_FFF8 and a 1-cycle memory covers PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        rst, PC_sel, stall, imem_ready, imem_rvalid;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instr_out, PC_out, NPC_out;

  logic        rst_b, b_psel, b_stall, b_ready, b_rvalid;
  logic [31:0] b_tgt, b_rdata;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_instr, b_pc, b_npc;

  int n_vec, n_err, cyc, mem_lat;
  logic [31:0] q_addr[$];
  int          q_due[$];

  fetch_unit #(.N(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .PC_sel(PC_sel), .branch_target(branch_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .valid_out(valid_out),
    .instr_out(instr_out), .PC_out(PC_out), .NPC_out(NPC_out)
  );

  fetch_unit #(.N(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .rst(rst_b), .PC_sel(b_psel), .branch_target(b_tgt), .stall(b_stall),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ready(b_ready),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata), .valid_out(b_valid),
    .instr_out(b_instr), .PC_out(b_pc), .NPC_out(b_npc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Advance one clock; outputs are then sampled #1 after the edge once the test has set inputs.
  task automatic tick();
    logic acc_a, rv_a, acc_b;
    logic [31:0] ad_a, ad_b;
    acc_a = imem_req & imem_ready; ad_a = imem_addr; rv_a = imem_rvalid;
    acc_b = b_req & b_ready;       ad_b = b_addr;
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      q_addr.delete(); q_due.delete();
    end else begin
      if (rv_a && q_addr.size() > 0) begin void'(q_addr.pop_front()); void'(q_due.pop_front()); end
      if (acc_a) begin q_addr.push_back(ad_a); q_due.push_back(cyc - 1 + mem_lat); end
    end
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin imem_rvalid = 1'b1; imem_rdata = f(q_addr[0]); end
    else begin imem_rvalid = 1'b0; imem_rdata = '0; end
    b_rvalid = acc_b & ~rst_b;
    b_rdata  = f(ad_b);
  endtask

  task automatic do_reset(input int lat);
    mem_lat = lat; rst = 1'b1; PC_sel = 1'b0; stall = 1'b0; branch_target = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mem_lat = 1; rst = 1'b1; PC_sel = 1'b0; stall = 1'b0;
    tick(); tick(); #1;
    n_vec++;
    if ({imem_req, valid_out, instr_out, PC_out, NPC_out} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
      n_err++; $display("FAIL reset_state: got %h want %h", {imem_req, valid_out, instr_out, PC_out, NPC_out},
                        {1'b0, 1'b0, 32'h0, 32'h0, 32'h4});
    end
    n_vec++;
    if ({b_req, b_valid, b_instr, b_pc, b_npc} !== {1'b0, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC}) begin
      n_err++; $display("FAIL reset_state_w: got %h want %h", {b_req, b_valid, b_instr, b_pc, b_npc},
                        {1'b0, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC});
    end
    rst = 1'b0; #1;
    n_vec++;
    if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL first_req: got %h want %h", {imem_req, imem_addr, valid_out}, {1'b1, 32'h0, 1'b0});
    end
  endtask

  task automatic test_stream();
    logic [31:0] p;
    do_reset(1);
    for (int k = 0; k < 7; k++) begin
      #1;
      n_vec++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * k)}) begin
        n_err++; $display("FAIL stream_req c%0d: got %h want %h", k, {imem_req, imem_addr}, {1'b1, 32'(4 * k)});
      end
      n_vec++;
      if (k < 2) begin
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL stream_valid c%0d: got %b want 0", k, valid_out); end
      end else begin
        p = 32'(4 * (k - 2));
        if ({valid_out, PC_out, NPC_out, instr_out} !== {1'b1, p, p + 32'd4, f(p)}) begin
          n_err++; $display("FAIL stream_out c%0d: got %h want %h", k, {valid_out, PC_out, NPC_out, instr_out},
                            {1'b1, p, p + 32'd4, f(p)});
        end
      end
      tick();
    end
  endtask

  // Tables: bit 32 set means a request / a valid head is expected at that address.
  task automatic test_stall();
    logic [32:0] ea [11] = '{33'h1_0000_0000, 33'h1_0000_0004, 33'h1_0000_0008, 33'h1_0000_000C, 33'h0, 33'h0,
                             33'h0, 33'h1_0000_0010, 33'h1_0000_0014, 33'h1_0000_0018, 33'h1_0000_001C};
    logic [32:0] ep [11] = '{33'h0, 33'h0, 33'h1_0000_0000, 33'h1_0000_0004, 33'h1_0000_0008, 33'h1_0000_0008,
                             33'h1_0000_0008, 33'h1_0000_0008, 33'h1_0000_000C, 33'h1_0000_0010, 33'h1_0000_0014};
    logic [31:0] p;
    do_reset(1);
    for (int k = 0; k < 11; k++) begin
      stall = (k >= 4 && k <= 6);
      #1;
      n_vec++;
      if (ea[k][32]) begin
        if ({imem_req, imem_addr} !== ea[k]) begin
          n_err++; $display("FAIL stall_req c%0d: got %h want %h", k, {imem_req, imem_addr}, ea[k]);
        end
      end else if (imem_req !== 1'b0) begin
        n_err++; $display("FAIL stall_req c%0d: got %b want 0", k, imem_req);
      end
      n_vec++;
      p = ep[k][31:0];
      if (ep[k][32]) begin
        if ({valid_out, PC_out, NPC_out, instr_out} !== {1'b1, p, p + 32'd4, f(p)}) begin
          n_err++; $display("FAIL stall_out c%0d: got %h want %h", k, {valid_out, PC_out, NPC_out, instr_out},
                            {1'b1, p, p + 32'd4, f(p)});
        end
      end else if (valid_out !== 1'b0) begin
        n_err++; $display("FAIL stall_valid c%0d: got %b want 0", k, valid_out);
      end
      tick();
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect();
    logic [32:0] ea [8] = '{33'h1_0000_0000, 33'h1_0000_0004, 33'h0, 33'h1_0000_0100, 33'h1_0000_0104, 33'h0,
                            33'h1_0000_0108, 33'h1_0000_010C};
    logic [32:0] ep [8] = '{33'h0, 33'h0, 33'h0, 33'h0, 33'h0, 33'h0, 33'h1_0000_0100, 33'h1_0000_0104};
    logic [31:0] p;
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      PC_sel = (k == 2); branch_target = 32'h100;
      #1;
      n_vec++;
      if (ea[k][32]) begin
        if ({imem_req, imem_addr} !== ea[k]) begin
          n_err++; $display("FAIL redir_req c%0d: got %h want %h", k, {imem_req, imem_addr}, ea[k]);
        end
      end else if (imem_req !== 1'b0) begin
        n_err++; $display("FAIL redir_req c%0d: got %b want 0", k, imem_req);
      end
      n_vec++;
      p = ep[k][31:0];
      if (ep[k][32]) begin
        if ({valid_out, PC_out, NPC_out, instr_out} !== {1'b1, p, p + 32'd4, f(p)}) begin
          n_err++; $display("FAIL redir_out c%0d: got %h want %h", k, {valid_out, PC_out, NPC_out, instr_out},
                            {1'b1, p, p + 32'd4, f(p)});
        end
      end else if (valid_out !== 1'b0) begin
        n_err++; $display("FAIL redir_valid c%0d: got %b want 0", k, valid_out);
      end
      tick();
    end
    PC_sel = 1'b0;
  endtask

  task automatic test_redirect_stall();
    logic [32:0] ea [6] = '{33'h1_0000_0000, 33'h1_0000_0004, 33'h0, 33'h1_0000_0200, 33'h1_0000_0204,
                            33'h1_0000_0208};
    logic [32:0] ep [6] = '{33'h0, 33'h0, 33'h0, 33'h0, 33'h0, 33'h1_0000_0200};
    logic [31:0] p;
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      PC_sel = (k == 2); stall = (k == 2); branch_target = 32'h200;
      #1;
      n_vec++;
      if (ea[k][32]) begin
        if ({imem_req, imem_addr} !== ea[k]) begin
          n_err++; $display("FAIL rdst_req c%0d: got %h want %h", k, {imem_req, imem_addr}, ea[k]);
        end
      end else if (imem_req !== 1'b0) begin
        n_err++; $display("FAIL rdst_req c%0d: got %b want 0", k, imem_req);
      end
      n_vec++;
      p = ep[k][31:0];
      if (ep[k][32]) begin
        if ({valid_out, PC_out, NPC_out, instr_out} !== {1'b1, p, p + 32'd4, f(p)}) begin
          n_err++; $display("FAIL rdst_out c%0d: got %h want %h", k, {valid_out, PC_out, NPC_out, instr_out},
                            {1'b1, p, p + 32'd4, f(p)});
        end
      end else if (valid_out !== 1'b0) begin
        n_err++; $display("FAIL rdst_valid c%0d: got %b want 0", k, valid_out);
      end
      tick();
    end
    PC_sel = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [32:0] ea [5] = '{33'h1_0000_0000, 33'h1_0000_0004, 33'h0, 33'h0, 33'h0};
    do_reset(2);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++;
      if (ea[k][32]) begin
        if ({imem_req, imem_addr} !== ea[k]) begin
          n_err++; $display("FAIL rmid_req c%0d: got %h want %h", k, {imem_req, imem_addr}, ea[k]);
        end
      end else if (imem_req !== 1'b0) begin
        n_err++; $display("FAIL rmid_req c%0d: got %b want 0", k, imem_req);
      end
      if (k < 4) tick();
    end
    n_vec++;
    if ({valid_out, PC_out, instr_out} !== {1'b1, 32'h0, f(32'h0)}) begin
      n_err++; $display("FAIL rmid_full: got %h want %h", {valid_out, PC_out, instr_out}, {1'b1, 32'h0, f(32'h0)});
    end
    rst = 1'b1; #1;
    n_vec++;
    if ({imem_req, valid_out, instr_out, PC_out, NPC_out} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
      n_err++; $display("FAIL rmid_during: got %h want %h", {imem_req, valid_out, instr_out, PC_out, NPC_out},
                        {1'b0, 1'b0, 32'h0, 32'h0, 32'h4});
    end
    tick(); #1;
    n_vec++;
    if ({imem_req, valid_out, instr_out, PC_out, NPC_out} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
      n_err++; $display("FAIL rmid_after: got %h want %h", {imem_req, valid_out, instr_out, PC_out, NPC_out},
                        {1'b0, 1'b0, 32'h0, 32'h0, 32'h4});
    end
    rst = 1'b0; stall = 1'b0; #1;
    n_vec++;
    if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL rmid_restart: got %h want %h", {imem_req, imem_addr, valid_out}, {1'b1, 32'h0, 1'b0});
    end
    tick(); tick(); tick(); #1;
    n_vec++;
    if ({valid_out, PC_out, NPC_out, instr_out} !== {1'b1, 32'h0, 32'h4, f(32'h0)}) begin
      n_err++; $display("FAIL rmid_first: got %h want %h", {valid_out, PC_out, NPC_out, instr_out},
                        {1'b1, 32'h0, 32'h4, f(32'h0)});
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] ea [6] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] ep [6] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    logic [31:0] en [6] = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    rst_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_vec++;
      if ({b_req, b_addr} !== {1'b1, ea[k]}) begin
        n_err++; $display("FAIL wrap_req c%0d: got %h want %h", k, {b_req, b_addr}, {1'b1, ea[k]});
      end
      n_vec++;
      if (k < 2) begin
        if (b_valid !== 1'b0) begin n_err++; $display("FAIL wrap_valid c%0d: got %b want 0", k, b_valid); end
      end else if ({b_valid, b_pc, b_npc, b_instr} !== {1'b1, ep[k], en[k], f(ep[k])}) begin
        n_err++; $display("FAIL wrap_out c%0d: got %h want %h", k, {b_valid, b_pc, b_npc, b_instr},
                          {1'b1, ep[k], en[k], f(ep[k])});
      end
      tick();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; mem_lat = 1;
    rst = 1'b1; PC_sel = 1'b0; stall = 1'b0; branch_target = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    rst_b = 1'b1; b_psel = 1'b0; b_stall = 1'b0; b_tgt = '0;
    b_ready = 1'b1; b_rvalid = 1'b0; b_rdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
